// File: rtl/pulse_sequencer_if.sv
// Parameter/strobe bundle between pulse_control (master) and pulse_sequencer (slave),
// carrying the timing registers in and the RF gate, blanking and sync outputs back.
interface pulse_sequencer_if #(
  parameter int PER_W = 32,
  parameter int WID_W = 16
);
  logic [PER_W-1:0] per;
  logic [WID_W-1:0] p1wid;
  logic [WID_W-1:0] del;
  logic [WID_W-1:0] p2wid;
  logic [7:0]       cp;
  logic [7:0]       p_bl;
  logic             bl;
  logic [7:0]       nut_w;
  logic [WID_W-1:0] nut_d;
  logic             rxd;
  logic             pulse;
  logic             inhib;
  logic             sync;

  modport master (
    output per, p1wid, del, p2wid, cp, p_bl, bl, nut_w, nut_d, rxd,
    input  pulse, inhib, sync
  );

  modport slave (
    input  per, p1wid, del, p2wid, cp, p_bl, bl, nut_w, nut_d, rxd,
    output pulse, inhib, sync
  );
endinterface

// File: rtl/pulse_sequencer.sv
// CPMG pulse sequencer: free-running period counter, double-buffered timing shadows and
// a P1/DEL/P2/GAP state machine. Define NUTATION_EN to prepend a NUT/NGAP pulse pair.
module pulse_sequencer #(
  parameter int PER_W = 32,
  parameter int WID_W = 16
) (
  input logic              clk,
  input logic              rst,
  pulse_sequencer_if.slave bus
);
  localparam int TW = WID_W + 1;

  typedef enum logic [2:0] {IDLE, NUT, NGAP, P1, DEL, P2, GAP, DONE} state_t;

  logic [PER_W-1:0] per_s, per_eff, cnt_reg, cnt_next;
  logic [WID_W-1:0] p1wid_s, del_s, p2wid_s;
  logic [7:0]       cp_s, p_bl_s;
  logic             bl_s;
`ifdef NUTATION_EN
  logic [7:0]       nut_w_s;
  logic [WID_W-1:0] nut_d_s;
`endif
  logic             pend_reg, rxd_d_reg, rxd_rise, wrap, load;
  state_t           state_reg, state_next, cur_state, succ, first_state;
  logic [TW-1:0]    tmr_reg, tmr_next, cur_tmr;
  logic [7:0]       k_reg, k_next, cur_k;
  logic             pulse_comb, pulse_reg, inhib_reg, sync_reg;
  logic [7:0]       blank_reg, blank_next;

  assign per_eff  = (per_s < PER_W'(2)) ? PER_W'(2) : per_s;
  assign wrap     = (cnt_reg >= per_eff - PER_W'(1));
  assign cnt_next = wrap ? '0 : cnt_reg + PER_W'(1);
  assign rxd_rise = bus.rxd & ~rxd_d_reg;
  assign load     = wrap & pend_reg;

  function automatic logic [TW-1:0] state_len(input state_t s);
    logic [TW-1:0] len;
    len = '0;
    case (s)
`ifdef NUTATION_EN
      NUT:     len = TW'(nut_w_s);
      NGAP:    len = TW'(nut_d_s);
`endif
      P1:      len = {1'b0, p1wid_s};
      DEL:     len = {1'b0, del_s};
      P2:      len = {1'b0, p2wid_s};
      GAP:     len = {del_s, 1'b0};
      default: len = '0;
    endcase
    return len;
  endfunction

  // Walk past zero-length states so every state we land in lasts at least one cycle.
  // With p2wid=0 no further edges can occur, so P2 collapses straight to DONE.
  function automatic state_t resolve(input state_t s);
    state_t r;
    r = s;
`ifdef NUTATION_EN
    if (r == NUT && nut_w_s == '0) r = P1;
    if (r == NGAP && nut_d_s == '0) r = P1;
`endif
    if (r == P1 && p1wid_s == '0) r = (cp_s == '0) ? DONE : DEL;
    if ((r == DEL || r == GAP) && del_s == '0) r = P2;
    if (r == P2 && p2wid_s == '0) r = DONE;
    return r;
  endfunction

`ifdef NUTATION_EN
  assign first_state = resolve(NUT);
`else
  assign first_state = resolve(P1);
`endif

  always_ff @(posedge clk) begin
    if (rst || load) begin
      per_s   <= bus.per;
      p1wid_s <= bus.p1wid;
      del_s   <= bus.del;
      p2wid_s <= bus.p2wid;
      cp_s    <= bus.cp;
      p_bl_s  <= bus.p_bl;
      bl_s    <= bus.bl;
`ifdef NUTATION_EN
      nut_w_s <= bus.nut_w;
      nut_d_s <= bus.nut_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      state_reg <= IDLE;
      tmr_reg   <= '0;
      k_reg     <= '0;
      pend_reg  <= 1'b0;
      rxd_d_reg <= 1'b0;
      pulse_reg <= 1'b0;
      inhib_reg <= 1'b0;
      sync_reg  <= 1'b0;
      blank_reg <= '0;
    end else begin
      cnt_reg   <= cnt_next;
      state_reg <= state_next;
      tmr_reg   <= tmr_next;
      k_reg     <= k_next;
      rxd_d_reg <= bus.rxd;
      // An edge arriving in the reload cycle itself is kept for the following wrap.
      pend_reg  <= load ? rxd_rise : (pend_reg | rxd_rise);
      pulse_reg <= pulse_comb;
      inhib_reg <= pulse_comb | (blank_next != '0);
      sync_reg  <= (cnt_reg == '0);
      blank_reg <= blank_next;
    end
  end

  always_comb begin
    cur_state = state_reg;
    cur_tmr   = tmr_reg;
    cur_k     = k_reg;
    if (cnt_reg == '0) begin
      cur_state = first_state;
      cur_tmr   = state_len(first_state);
      cur_k     = '0;
    end
    case (cur_state)
      NUT:     succ = NGAP;
      NGAP:    succ = P1;
      P1:      succ = (cp_s == '0) ? DONE : DEL;
      DEL:     succ = P2;
      P2:      succ = (({1'b0, cur_k} + 9'd1) < {1'b0, cp_s}) ? GAP : DONE;
      GAP:     succ = P2;
      default: succ = DONE;
    endcase
    state_next = cur_state;
    tmr_next   = cur_tmr;
    k_next     = cur_k;
    if (cur_state != IDLE && cur_state != DONE) begin
      if (cur_tmr <= TW'(1)) begin
        if (cur_state == P2) k_next = cur_k + 8'd1;
        state_next = resolve(succ);
        tmr_next   = state_len(resolve(succ));
      end else begin
        tmr_next = cur_tmr - TW'(1);
      end
    end
  end

  always_comb begin
    pulse_comb = 1'b0;
    case (cur_state)
      NUT, P2: pulse_comb = 1'b1;
      P1:      pulse_comb = bl_s;
      default: pulse_comb = 1'b0;
    endcase
    blank_next = '0;
    if (cnt_reg != '0) begin
      if (pulse_reg && !pulse_comb) blank_next = p_bl_s;
      else if (blank_reg != '0)     blank_next = blank_reg - 8'd1;
    end
  end

  assign bus.pulse = pulse_reg;
  assign bus.inhib = inhib_reg;
  assign bus.sync  = sync_reg;
endmodule

// File: tb/tb_pulse_sequencer.sv
// Table-driven bench for pulse_sequencer: each vector resets the DUT with a parameter set,
// then compares pulse/inhib/sync cycle by cycle against hand-derived windows.
module tb_pulse_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  pulse_sequencer_if bus ();
  pulse_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed { int lo; int hi; } win_t;
  typedef struct packed { int cyc; logic rxd; logic [15:0] p1; } ev_t;
  typedef struct packed {
    int per; logic [15:0] p1; logic [15:0] dl; logic [15:0] p2;
    logic [7:0] cpv; logic blv; logic [7:0] pbl; logic [7:0] nw; logic [15:0] nd;
    int ncyc;
    win_t [4:0] pw;
    win_t [4:0] iw;
    ev_t  [4:0] ev;
  } test_t;
  typedef struct { logic p; logic i; logic s; int cyc; } exp_t;

  localparam int NT = 12;
  test_t tests [NT];
  exp_t  sb [$];

  function automatic test_t mk(int per, int p1, int dl, int p2, int cpv, int blv, int pbl,
                               int nw, int nd, int ncyc);
    test_t t;
    t = '0;
    t.per = per; t.p1 = 16'(p1); t.dl = 16'(dl); t.p2 = 16'(p2); t.cpv = 8'(cpv);
    t.blv = blv[0]; t.pbl = 8'(pbl); t.nw = 8'(nw); t.nd = 16'(nd); t.ncyc = ncyc;
    for (int i = 0; i < 5; i++) begin
      t.pw[i] = '{-1, -2};
      t.iw[i] = '{-1, -2};
      t.ev[i] = '{-1, 1'b0, 16'd0};
    end
    return t;
  endfunction

  function automatic logic in_win(win_t [4:0] w, int n);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 5; i++) if (n >= w[i].lo && n <= w[i].hi) r = 1'b1;
    return r;
  endfunction

  task automatic drive(input test_t t);
    bus.per = 32'(t.per); bus.p1wid = t.p1; bus.del = t.dl; bus.p2wid = t.p2;
    bus.cp = t.cpv; bus.bl = t.blv; bus.p_bl = t.pbl; bus.nut_w = t.nw; bus.nut_d = t.nd;
    bus.rxd = 1'b0;
  endtask

  task automatic check3(input string name, input logic [2:0] got, input logic [2:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got pulse/inhib/sync=%b want %b", name, got, want);
    end
  endtask

  task automatic run_vec(input test_t t, input int idx);
    int perq;
    int nbad [3];
    int first [3];
    logic [2:0] fgot [3];
    logic [2:0] got;
    exp_t e;
    string nm [3];
    nm = '{"pulse", "inhib", "sync"};
    perq = (t.per < 2) ? 2 : t.per;
    drive(t);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check3($sformatf("vec%0d reset", idx), {bus.pulse, bus.inhib, bus.sync}, 3'b000);
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin nbad[j] = 0; first[j] = -1; fgot[j] = '0; end
    for (int n = 0; n < t.ncyc; n++) begin
      sb.push_back('{in_win(t.pw, n), in_win(t.iw, n), (n % perq) == 0, n});
      @(negedge clk);
      got = {bus.pulse, bus.inhib, bus.sync};
      e = sb.pop_front();
      for (int j = 0; j < 3; j++) begin
        if (got[2-j] !== (j == 0 ? e.p : (j == 1 ? e.i : e.s))) begin
          if (nbad[j] == 0) begin first[j] = e.cyc; fgot[j] = got; end
          nbad[j]++;
        end
      end
      for (int k = 0; k < 5; k++) begin
        if (t.ev[k].cyc == n) begin
          bus.rxd = t.ev[k].rxd;
          bus.p1wid = t.ev[k].p1;
        end
      end
    end
    for (int j = 0; j < 3; j++) begin
      total++;
      if (nbad[j] != 0) begin
        bad++;
        $display("FAIL vec%0d %s: %0d bad cycles, first at cycle %0d got p/i/s=%b, want %s=%b",
                 idx, nm[j], nbad[j], first[j], fgot[j], nm[j], ~fgot[j][2-j]);
      end
    end
  endtask

  initial begin
    test_t d;
    drive(mk(2000, 30, 200, 60, 1, 1, 50, 0, 0, 1));
    // Defaults, observed one cycle into the next period.
    tests[0] = mk(2000, 30, 200, 60, 1, 1, 50, 0, 0, 2001);
    tests[0].pw[0] = '{0, 29};  tests[0].pw[1] = '{230, 289}; tests[0].pw[2] = '{2000, 2000};
    tests[0].iw[0] = '{0, 79};  tests[0].iw[1] = '{230, 339}; tests[0].iw[2] = '{2000, 2000};
    tests[1] = mk(2000, 30, 200, 60, 3, 1, 50, 0, 0, 2000);
    tests[1].pw[0] = '{0, 29};  tests[1].pw[1] = '{230, 289};
    tests[1].pw[2] = '{690, 749}; tests[1].pw[3] = '{1150, 1209};
    tests[1].iw[0] = '{0, 79};  tests[1].iw[1] = '{230, 339};
    tests[1].iw[2] = '{690, 799}; tests[1].iw[3] = '{1150, 1259};
    tests[2] = mk(2000, 30, 200, 60, 1, 0, 50, 0, 0, 2000);
    tests[2].pw[0] = '{230, 289}; tests[2].iw[0] = '{230, 339};
    tests[3] = mk(100, 30, 200, 60, 1, 1, 50, 0, 0, 300);
    tests[3].pw[0] = '{0, 29};  tests[3].pw[1] = '{100, 129}; tests[3].pw[2] = '{200, 229};
    tests[3].iw[0] = '{0, 79};  tests[3].iw[1] = '{100, 179}; tests[3].iw[2] = '{200, 279};
    // del=0 merges p1 and both p2 pulses into one block; p_bl=0 gives no blanking tail.
    tests[4] = mk(400, 30, 0, 60, 2, 1, 0, 0, 0, 400);
    tests[4].pw[0] = '{0, 149}; tests[4].iw[0] = '{0, 149};
    tests[5] = mk(500, 30, 200, 60, 0, 1, 50, 0, 0, 500);
    tests[5].pw[0] = '{0, 29};  tests[5].iw[0] = '{0, 79};
    tests[6] = mk(500, 0, 200, 60, 1, 1, 50, 0, 0, 500);
    tests[6].pw[0] = '{200, 259}; tests[6].iw[0] = '{200, 309};
    tests[7] = mk(500, 30, 200, 0, 1, 1, 50, 0, 0, 500);
    tests[7].pw[0] = '{0, 29};  tests[7].iw[0] = '{0, 79};
    // per=1 behaves as per=2: p1 restarts every two cycles, so pulse never falls.
    tests[8] = mk(1, 30, 200, 60, 1, 1, 50, 0, 0, 10);
    tests[8].pw[0] = '{0, 9};   tests[8].iw[0] = '{0, 9};
    // Update mid-period: new p1 width only from the next period.
    tests[9] = mk(2000, 30, 200, 60, 1, 1, 50, 0, 0, 2300);
    tests[9].ev[0] = '{499, 1'b1, 16'd40}; tests[9].ev[1] = '{500, 1'b0, 16'd40};
    tests[9].pw[0] = '{0, 29};  tests[9].pw[1] = '{230, 289};
    tests[9].pw[2] = '{2000, 2039}; tests[9].pw[3] = '{2240, 2299};
    tests[9].iw[0] = '{0, 79};  tests[9].iw[1] = '{230, 339};
    tests[9].iw[2] = '{2000, 2089}; tests[9].iw[3] = '{2240, 2299};
    // Second rxd edge lands in the wrap cycle: reload happens and pend survives to the next wrap.
    tests[10] = mk(2000, 30, 200, 60, 1, 1, 50, 0, 0, 4070);
    tests[10].ev[0] = '{499, 1'b1, 16'd40};  tests[10].ev[1] = '{500, 1'b0, 16'd40};
    tests[10].ev[2] = '{1998, 1'b1, 16'd50}; tests[10].ev[3] = '{1999, 1'b0, 16'd50};
    tests[10].ev[4] = '{2100, 1'b0, 16'd70};
    tests[10].pw[0] = '{0, 29};  tests[10].pw[1] = '{230, 289}; tests[10].pw[2] = '{2000, 2049};
    tests[10].pw[3] = '{2250, 2309}; tests[10].pw[4] = '{4000, 4069};
    tests[10].iw[0] = '{0, 79};  tests[10].iw[1] = '{230, 339}; tests[10].iw[2] = '{2000, 2099};
    tests[10].iw[3] = '{2250, 2359}; tests[10].iw[4] = '{4000, 4069};
    tests[11] = mk(2000, 30, 200, 60, 1, 1, 50, 10, 100, 2000);
`ifdef NUTATION_EN
    tests[11].pw[0] = '{0, 9};  tests[11].pw[1] = '{110, 139}; tests[11].pw[2] = '{340, 399};
    tests[11].iw[0] = '{0, 59}; tests[11].iw[1] = '{110, 189}; tests[11].iw[2] = '{340, 449};
`else
    tests[11].pw[0] = '{0, 29}; tests[11].pw[1] = '{230, 289};
    tests[11].iw[0] = '{0, 79}; tests[11].iw[1] = '{230, 339};
`endif

    for (int v = 0; v < NT; v++) run_vec(tests[v], v);

    // Reset asserted in the middle of a p2 pulse, then released.
    d = mk(2000, 30, 200, 60, 1, 1, 50, 0, 0, 0);
    drive(d);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (241) @(negedge clk);
    check3("midrun c240", {bus.pulse, bus.inhib, bus.sync}, 3'b110);
    rst = 1'b1;
    @(negedge clk);
    check3("midrst drop", {bus.pulse, bus.inhib, bus.sync}, 3'b000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check3("restart c0", {bus.pulse, bus.inhib, bus.sync}, 3'b111);
    repeat (229) @(negedge clk);
    check3("restart c229", {bus.pulse, bus.inhib, bus.sync}, 3'b000);
    @(negedge clk);
    check3("restart c230", {bus.pulse, bus.inhib, bus.sync}, 3'b110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
